// File: rtl/delay_meas_ctrl.sv
// Delay measurement controller.
// Launches a rising and then a falling edge into a delay chain and counts the
// clk cycles until the synchronized chain output reaches its expected level.
// A phase gives up with a timeout once its count would reach TIMEOUT.
module delay_meas_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INVERT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sense,
  output logic             drive,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RISE,
    FALL,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ssense;
  logic                   exp_lvl;
  logic                   match;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   cnt_expired;
  logic                   drive_d;
  logic                   timeout_d;
  logic [CNT_W-1:0]       rise_d, fall_d;

  // Sense synchronizer; stages reset to the level an idle chain presents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INVERT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sense};
    end
  end

  assign ssense      = sync_q[SYNC_STAGES-1];
  assign exp_lvl     = drive ^ INVERT;
  assign match       = (ssense == exp_lvl);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign cnt_expired = (cnt_inc == TO_VAL);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // State, stimulus, phase counter and captured results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      drive    <= 1'b0;
      cnt_q    <= '0;
      timeout  <= 1'b0;
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      state_q  <= state_d;
      drive    <= drive_d;
      cnt_q    <= cnt_d;
      timeout  <= timeout_d;
      rise_cnt <= rise_d;
      fall_cnt <= fall_d;
    end
  end

  // Next-state logic. The counter clears on the same edge that toggles drive,
  // so a zero-delay chain reads back as SYNC_STAGES cycles.
  always_comb begin
    state_d   = state_q;
    drive_d   = drive;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    rise_d    = rise_cnt;
    fall_d    = fall_cnt;
    unique case (state_q)
      IDLE: begin
        drive_d = 1'b0;
        if (start) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        drive_d = 1'b0;
        if (match) begin
          state_d = RISE;
          cnt_d   = '0;
          drive_d = 1'b1;
        end else if (cnt_expired) begin
          state_d   = DONE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          rise_d    = TO_VAL;
          fall_d    = TO_VAL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RISE: begin
        if (match) begin
          state_d = FALL;
          rise_d  = cnt_q;
          cnt_d   = '0;
          drive_d = 1'b0;
        end else if (cnt_expired) begin
          state_d   = DONE;
          cnt_d     = '0;
          drive_d   = 1'b0;
          timeout_d = 1'b1;
          rise_d    = TO_VAL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FALL: begin
        if (match) begin
          state_d = DONE;
          fall_d  = cnt_q;
          cnt_d   = '0;
          drive_d = 1'b0;
        end else if (cnt_expired) begin
          state_d   = DONE;
          cnt_d     = '0;
          drive_d   = 1'b0;
          timeout_d = 1'b1;
          fall_d    = TO_VAL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Bench for delay_meas_ctrl: directed vector table, reset-abort sequence and
// randomized runs against an arithmetic model of the measured delays.
module tb_delay_meas_ctrl;

  localparam int unsigned CW = 8;
  localparam int unsigned TO = 200;
  localparam int unsigned SS = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sense = 1'b1;
  logic          drive, busy, done, timeout;
  logic [CW-1:0] rise_cnt, fall_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  delay_meas_ctrl #(
    .CNT_W(CW),
    .TIMEOUT(TO),
    .SYNC_STAGES(SS),
    .INVERT(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .sense(sense),
    .drive(drive),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .rise_cnt(rise_cnt),
    .fall_cnt(fall_cnt)
  );

  // Chain model: rising edges of drive appear rd_cfg cycles later, falling
  // edges fd_cfg cycles later, output inverted. mode 1/2 force sense 1/0.
  int unsigned  rd_cfg  = 0;
  int unsigned  fd_cfg  = 0;
  int           mode    = 0;
  int unsigned  cfg_seq = 0;
  int unsigned  seen_seq = 0;
  logic [299:0] dh = '0;
  logic         chain_out = 1'b0;

  always @(negedge clk) begin
    if (cfg_seq != seen_seq) begin
      seen_seq  = cfg_seq;
      dh        = '0;
      chain_out = 1'b0;
    end
    dh = {dh[298:0], drive};
    if (!dh[fd_cfg] && dh[fd_cfg+1]) chain_out = 1'b0;
    else if (dh[rd_cfg] && !dh[rd_cfg+1]) chain_out = 1'b1;
    case (mode)
      1:       sense = 1'b1;
      2:       sense = 1'b0;
      default: sense = ~chain_out;
    endcase
  end

  int unsigned done_pulses = 0;
  int unsigned drive_hi    = 0;
  int unsigned to_viol     = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
    if (drive === 1'b1) drive_hi++;
    if ((timeout === 1'b1 && done !== 1'b1) || (done === 1'b1 && busy !== 1'b1)) to_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic set_chain(input int unsigned rd, input int unsigned fd, input int md);
    rd_cfg = rd;
    fd_cfg = fd;
    mode   = md;
    cfg_seq++;
    repeat (SS + 6) @(negedge clk);
  endtask

  // One measurement: start at a negedge, count edges until done is seen.
  task automatic run(input int unsigned rd, input int unsigned fd, input int md,
                     input int unsigned spur, input logic sid, input string tag,
                     output int unsigned lat, output logic to_seen,
                     output int unsigned r, output int unsigned f);
    int unsigned dp0, dh0;
    logic got;
    set_chain(rd, fd, md);
    dp0   = done_pulses;
    dh0   = drive_hi;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; to_seen = 1'b0; r = 0; f = 0; got = 1'b0;
    for (int unsigned n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      start = (spur != 0 && n == spur);
      if (done) begin
        lat     = n;
        to_seen = timeout;
        r       = 32'(rise_cnt);
        f       = 32'(fall_cnt);
        got     = 1'b1;
        start   = sid;
        break;
      end
    end
    if (!got) chk({tag, "/done_wait"}, 32'(got), 1);
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "/done_once"}, done_pulses - dp0, 1);
    chk({tag, "/post_idle"}, 32'({done, busy, drive, timeout}), 0);
    @(posedge clk);
    #1 chk({tag, "/no_queue"}, 32'(busy), 0);
    if (md == 2) chk({tag, "/no_drive"}, drive_hi - dh0, 0);
  endtask

  typedef struct {
    int unsigned rd;
    int unsigned fd;
    int          md;
    logic        to;
    int unsigned r;
    int unsigned f;
    int unsigned lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int unsigned lat, r, f, m_fall;
    logic tos, got;
    int unsigned dp0;

    tbl[0] = '{0,   0,   0, 1'b0, 2,   2,   7};
    tbl[1] = '{10,  10,  0, 1'b0, 12,  12,  27};
    tbl[2] = '{3,   7,   0, 1'b0, 5,   9,   17};
    tbl[3] = '{7,   3,   0, 1'b0, 9,   5,   17};
    tbl[4] = '{197, 0,   0, 1'b0, 199, 2,   204};
    tbl[5] = '{0,   197, 0, 1'b0, 2,   199, 204};
    tbl[6] = '{198, 0,   0, 1'b1, 200, 199, 201};
    tbl[7] = '{0,   0,   1, 1'b1, 200, 199, 201};
    tbl[8] = '{0,   198, 0, 1'b1, 2,   200, 204};
    tbl[9] = '{0,   0,   2, 1'b1, 200, 200, 200};

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("reset/ctrl", 32'({drive, busy, done, timeout}), 0);
    chk("reset/rise", 32'(rise_cnt), 0);
    chk("reset/fall", 32'(fall_cnt), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("reset/stay_idle", 32'({busy, drive}), 0);

    // Directed vectors.
    for (int unsigned i = 0; i < 10; i++) begin
      run(tbl[i].rd, tbl[i].fd, tbl[i].md, 0, (i % 3 == 1), $sformatf("vec%0d", i),
          lat, tos, r, f);
      chk($sformatf("vec%0d/lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d/timeout", i), 32'(tos), 32'(tbl[i].to));
      chk($sformatf("vec%0d/rise", i), r, tbl[i].r);
      chk($sformatf("vec%0d/fall", i), f, tbl[i].f);
    end

    // Abort during FALL with a spurious start in RISE.
    set_chain(10, 10, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int unsigned n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (drive) begin got = 1'b1; break; end
    end
    chk("abort/rise_seen", 32'(got), 1);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int unsigned n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (!drive) begin got = 1'b1; break; end
    end
    chk("abort/fall_seen", 32'(got), 1);
    chk("abort/rise_before", 32'(rise_cnt), 12);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort/ctrl", 32'({drive, busy, done, timeout}), 0);
    chk("abort/counts", 32'({rise_cnt, fall_cnt}), 0);
    dp0 = done_pulses;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort/no_done", done_pulses - dp0, 0);
    chk("abort/idle", 32'(busy), 0);
    run(0, 0, 0, 0, 1'b0, "after_abort", lat, tos, r, f);
    chk("after_abort/lat", lat, 7);
    chk("after_abort/rise", r, 2);
    chk("after_abort/fall", f, 2);
    m_fall = 2;

    // Randomized runs against the delay arithmetic.
    for (int unsigned k = 0; k < 40; k++) begin
      int unsigned rd, fd, cr, cf, e_r, e_f, e_lat, spur;
      logic e_to, sid;
      rd = ($urandom_range(0, 9) == 0) ? $urandom_range(190, 205) : $urandom_range(0, 25);
      fd = ($urandom_range(0, 9) == 0) ? $urandom_range(190, 205) : $urandom_range(0, 25);
      cr = rd + SS;
      cf = fd + SS;
      if (cr >= TO) begin
        e_to = 1'b1; e_r = TO; e_f = m_fall; e_lat = TO + 1;
      end else if (cf >= TO) begin
        e_to = 1'b1; e_r = cr; e_f = TO; e_lat = cr + 2 + TO;
      end else begin
        e_to = 1'b0; e_r = cr; e_f = cf; e_lat = cr + cf + 3;
      end
      m_fall = e_f;
      spur = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e_lat) : 0;
      sid  = 1'($urandom_range(0, 1));
      run(rd, fd, 0, spur, sid, $sformatf("rnd%0d", k), lat, tos, r, f);
      chk($sformatf("rnd%0d/lat rd=%0d fd=%0d", k, rd, fd), lat, e_lat);
      chk($sformatf("rnd%0d/timeout", k), 32'(tos), 32'(e_to));
      chk($sformatf("rnd%0d/rise", k), r, e_r);
      chk($sformatf("rnd%0d/fall", k), f, e_f);
    end

    chk("timeout_outside_done", to_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/delay_meas_ctrl.md
DELAY_MEAS_CTRL -- requirements
Module: delay_meas_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each measured-delay count.
REQ-002 SHALL have parameter TIMEOUT, default 200: maximum wait cycles per phase; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages in the sense synchronizer; legal range 2..4.
REQ-004 SHALL have parameter INVERT, default 1: 1 = the chain under test is inverting, so expected sense = ~drive; 0 = expected sense = drive.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 start  input  1  one-cycle request to run a measurement.
REQ-008 sense  input  1  asynchronous output of the delay chain under test.
REQ-009 drive  output  1  registered stimulus driven into the chain input.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a run ends, whether passed or timed out.
REQ-012 timeout  output  1  one-cycle pulse coincident with done when the run failed.
REQ-013 rise_cnt  output  CNT_W  measured rising-launch delay in clk cycles.
REQ-014 fall_cnt  output  CNT_W  measured falling-launch delay in clk cycles.

Function
REQ-015 sense SHALL pass through a SYNC_STAGES-deep synchronizer; all FSM decisions SHALL use only the last synchronizer stage (ssense).
REQ-016 The expected value exp SHALL be drive ^ INVERT.
REQ-017 FSM states SHALL be IDLE, SETTLE, RISE, FALL and DONE; the state register and drive SHALL both be registered.
REQ-018 IDLE: drive=0; start=1 -> SETTLE, with the phase counter cleared.
REQ-019 SETTLE: drive=0; ssense==exp -> RISE, counter cleared, drive<=1 on the same edge.
REQ-020 SETTLE: on any cycle where ssense!=exp, the counter SHALL increment.
REQ-021 RISE: on each cycle with ssense!=exp, the counter SHALL increment.
REQ-022 RISE: on the first cycle with ssense==exp, rise_cnt<=counter, counter cleared, drive<=0, state -> FALL.
REQ-023 FALL: SHALL behave like RISE, capturing fall_cnt, then -> DONE.
REQ-024 DONE SHALL last one cycle, assert done, then -> IDLE.
REQ-025 Count definition: the counter SHALL be cleared on the edge that changes drive; with a zero-delay chain, the captured count SHALL equal SYNC_STAGES.
REQ-026 A chain delay of N whole cycles SHALL be captured as N+SYNC_STAGES.
REQ-027 Timeout: when the counter would reach TIMEOUT in SETTLE, RISE or FALL, the FSM SHALL go to DONE with drive<=0, and timeout SHALL pulse with done.
REQ-028 On a timeout, the count of the failing phase SHALL be written as TIMEOUT; for a SETTLE failure, rise_cnt and fall_cnt SHALL both be TIMEOUT; counts of phases already finished SHALL keep their new values.
REQ-029 rise_cnt and fall_cnt SHALL hold their values until the next capture or reset.
REQ-030 The counter SHALL never wrap, because TIMEOUT < 2^CNT_W.
REQ-031 start while busy=1 SHALL be ignored, with no queuing.
REQ-032 start in the DONE cycle SHALL be ignored; a new run requires start in IDLE.
REQ-033 done and timeout SHALL never assert outside DONE.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state=IDLE, drive=0, busy=0, done=0, timeout=0, rise_cnt=0, fall_cnt=0, counter=0, and all synchronizer stages=INVERT.
REQ-035 Reset SHALL abort any run mid-phase; no done pulse SHALL follow the abort.
REQ-036 After rst_n deasserts, the first run SHALL start only on a start in IDLE.

Verification
REQ-037 Defaults; sense=~drive with zero delay; pulse start -> rise_cnt=2, fall_cnt=2, done pulses once, timeout=0, busy returns low.
REQ-038 sense=~drive delayed 10 cycles -> rise_cnt=12, fall_cnt=12.
REQ-039 Asymmetric delay (rise 3 cycles, fall 7 cycles) -> rise_cnt=5, fall_cnt=9.
REQ-040 sense stuck at 1 after settle -> drive rises, timeout and done pulse 200 cycles later, rise_cnt=200, drive=0.
REQ-041 sense stuck at 0 with INVERT=1 -> SETTLE fails, timeout pulses, both counts=200, drive never rises.
REQ-042 start re-pulsed during RISE, then rst_n pulsed low during FALL -> second start ignored; after reset all outputs=0, no done pulse; next start runs normally.
